// File: rtl/cpu_onchip_memory_burst.sv
// Single-port on-chip RAM with an Avalon-MM slave port.
// Supports byte-lane writes, incrementing read/write bursts and a 1- or
// 2-cycle pipelined read return with readdatavalid. A stall (clken low or
// reset_req high) freezes the FSM and the read pipeline in place.
module cpu_onchip_memory_burst #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    BURST_WIDTH  = 4,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [BURST_WIDTH-1:0]  burstcount,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   next_addr, addr_nxt;
  logic [BURST_WIDTH-1:0]  remaining, rem_nxt;
  logic                    stall;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic                    rd_issue;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // Contents are not reset; preload comes from the device init flow.
  (* ram_init_file = INIT_FILE *)
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  // Read pipeline: stage s holds a beat issued s unstalled cycles ago.
  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  assign stall       = ~clken | reset_req;
  assign waitrequest = stall | (state == RD_BURST);

  // Next-state, burst bookkeeping and per-cycle memory strobes.
  // Every action requires ~stall, so a stall simply holds all state.
  always_comb begin
    state_nxt = state;
    addr_nxt  = next_addr;
    rem_nxt   = remaining;
    mem_we    = 1'b0;
    mem_waddr = address;
    rd_issue  = 1'b0;
    rd_addr   = address;
    unique case (state)
      IDLE: begin
        // Write wins over a simultaneous read.
        if (chipselect && write && !stall) begin
          mem_we = 1'b1;
          if (burstcount > BURST_ONE) begin
            addr_nxt  = address + ADDR_ONE;
            rem_nxt   = burstcount - BURST_ONE;
            state_nxt = WR_BURST;
          end
        end else if (chipselect && read && !stall) begin
          rd_issue = 1'b1;
          if (burstcount > BURST_ONE) begin
            addr_nxt  = address + ADDR_ONE;
            rem_nxt   = burstcount - BURST_ONE;
            state_nxt = RD_BURST;
          end
        end
      end
      WR_BURST: begin
        // write low is an idle beat; address/burstcount are ignored here.
        if (write && !stall) begin
          mem_we    = 1'b1;
          mem_waddr = next_addr;
          addr_nxt  = next_addr + ADDR_ONE;
          rem_nxt   = remaining - BURST_ONE;
          if (remaining == BURST_ONE) state_nxt = IDLE;
        end
      end
      RD_BURST: begin
        // One beat per unstalled cycle, independent of read.
        if (!stall) begin
          rd_issue = 1'b1;
          rd_addr  = next_addr;
          addr_nxt = next_addr + ADDR_ONE;
          rem_nxt  = remaining - BURST_ONE;
          if (remaining == BURST_ONE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and burst counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      next_addr <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      next_addr <= addr_nxt;
      remaining <= rem_nxt;
    end
  end

  // Byte-lane write port; disabled lanes keep their old content.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (byteenable[l]) mem[mem_waddr][l] <= writedata[8*l +: 8];
      end
    end
  end

  // Read pipeline; reset discards in-flight beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (!stall) begin
      vld_pipe[1] <= rd_issue;
      dat_pipe[1] <= mem[rd_addr];
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign readdata      = dat_pipe[READ_LATENCY];
  assign readdatavalid = vld_pipe[READ_LATENCY] & ~stall;

endmodule
